// File: rtl/controlador_matriz_if.sv
// Row/frame bus between the matrix sequencer and the LED datapath plus its
// operator controls. master = sequencer side, slave = datapath/control side.
interface controlador_matriz_if;
    logic       habilitar;
    logic       modo_auto;
    logic       avancar;
    logic [2:0] contador;
    logic [1:0] quadro_sel;
    logic [6:0] linhas;
    logic       fim_varredura;

    modport master (
        input  habilitar,
        input  modo_auto,
        input  avancar,
        output contador,
        output quadro_sel,
        output linhas,
        output fim_varredura
    );

    modport slave (
        output habilitar,
        output modo_auto,
        output avancar,
        input  contador,
        input  quadro_sel,
        input  linhas,
        input  fim_varredura
    );
endinterface

// File: rtl/controlador_matriz.sv
// Row scanner and frame selector for the 5x7 LED matrix; frames change only at scan wrap.
// Optional inter-row blanking state is enabled by defining the macro BRANCO_EN.
module controlador_matriz #(
    parameter int DIV_LINHA             = 1000,
    parameter int N_LINHAS              = 7,
    parameter int N_QUADROS             = 4,
    parameter int VARREDURAS_POR_QUADRO = 50,
    parameter int DIV_BRANCO            = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    controlador_matriz_if.master bus
);

    localparam int PRESC_MAX = (DIV_LINHA > DIV_BRANCO) ? DIV_LINHA : DIV_BRANCO;
    localparam int PRESC_W   = $clog2(PRESC_MAX);
    localparam int VARR_W    = $clog2(VARREDURAS_POR_QUADRO + 1);

    localparam logic [PRESC_W-1:0] PRESC_FIM_LINHA = PRESC_W'(DIV_LINHA - 1);
    localparam logic [2:0]         ULTIMA_LINHA    = 3'(N_LINHAS - 1);
    localparam logic [1:0]         ULTIMO_QUADRO   = 2'(N_QUADROS - 1);
    localparam logic [VARR_W-1:0]  VARR_ALVO       = VARR_W'(VARREDURAS_POR_QUADRO);
`ifdef BRANCO_EN
    localparam logic [PRESC_W-1:0] PRESC_FIM_BRANCO = PRESC_W'(DIV_BRANCO - 1);
`endif

    typedef enum logic [1:0] {
        PARADO   = 2'd0,
        VARRENDO = 2'd1
`ifdef BRANCO_EN
        , BRANCO = 2'd2
`endif
    } estado_t;

    // Active-low one-hot row pattern; an index past the 7 drivers lights nothing
    function automatic logic [6:0] linha_ativa(input logic [2:0] idx);
        logic [7:0] mascara;
        mascara = 8'b0000_0001 << idx;
        return ~mascara[6:0];
    endfunction

    estado_t             estado_r;
    logic [PRESC_W-1:0]  presc_r;
    logic [VARR_W-1:0]   cont_varr_r;
    logic                pendente_r;
    logic                avancar_ant_r;
    logic                modo_ant_r;
    logic [2:0]          contador_r;
    logic [1:0]          quadro_sel_r;
    logic [6:0]          linhas_r;
    logic                fim_varredura_r;

    logic                borda_s;
    logic                modo_mudou_s;
    logic [VARR_W-1:0]   varr_prox_s;
    logic                troca_auto_s;
    logic [2:0]          contador_prox_s;
    logic [1:0]          quadro_prox_s;
    logic                fim_linha_s;
    logic                fecha_varr_s;

    assign bus.contador      = contador_r;
    assign bus.quadro_sel    = quadro_sel_r;
    assign bus.linhas        = linhas_r;
    assign bus.fim_varredura = fim_varredura_r;

    // Next-value helpers: button edge, wrap detection and counter successors
    always_comb begin
        borda_s      = bus.avancar & ~avancar_ant_r;
        modo_mudou_s = bus.modo_auto ^ modo_ant_r;
        varr_prox_s  = cont_varr_r + VARR_W'(1);
        troca_auto_s = bus.modo_auto & (varr_prox_s == VARR_ALVO);
        fim_linha_s  = (estado_r == VARRENDO) & bus.habilitar & (presc_r == PRESC_FIM_LINHA);
        if (contador_r == ULTIMA_LINHA) begin
            contador_prox_s = 3'd0;
        end else begin
            contador_prox_s = contador_r + 3'd1;
        end
        if (quadro_sel_r == ULTIMO_QUADRO) begin
            quadro_prox_s = 2'd0;
        end else begin
            quadro_prox_s = quadro_sel_r + 2'd1;
        end
        if (fim_linha_s && (contador_r == ULTIMA_LINHA)) begin
            fecha_varr_s = 1'b1;
        end else begin
            fecha_varr_s = 1'b0;
        end
    end

    // Sequencer FSM with registered row/frame outputs and scan book-keeping
    always_ff @(posedge clk) begin
        if (reset) begin
            estado_r        <= PARADO;
            presc_r         <= '0;
            cont_varr_r     <= '0;
            pendente_r      <= 1'b0;
            avancar_ant_r   <= 1'b0;
            modo_ant_r      <= 1'b0;
            contador_r      <= 3'd0;
            quadro_sel_r    <= 2'd0;
            linhas_r        <= 7'h7F;
            fim_varredura_r <= 1'b0;
        end else begin
            avancar_ant_r   <= bus.avancar;
            modo_ant_r      <= bus.modo_auto;
            fim_varredura_r <= fecha_varr_s;

            // An edge arriving on the wrap cycle itself is kept for the next scan
            if (fecha_varr_s) begin
                pendente_r <= borda_s;
                if (pendente_r || troca_auto_s) begin
                    quadro_sel_r <= quadro_prox_s;
                end else begin
                    quadro_sel_r <= quadro_sel_r;
                end
                if (!bus.modo_auto || modo_mudou_s || troca_auto_s) begin
                    cont_varr_r <= '0;
                end else begin
                    cont_varr_r <= varr_prox_s;
                end
            end else begin
                pendente_r   <= pendente_r | borda_s;
                quadro_sel_r <= quadro_sel_r;
                if (!bus.modo_auto || modo_mudou_s || !bus.habilitar) begin
                    cont_varr_r <= '0;
                end else begin
                    cont_varr_r <= cont_varr_r;
                end
            end

            case (estado_r)
                PARADO: begin
                    presc_r    <= '0;
                    contador_r <= 3'd0;
                    if (bus.habilitar) begin
                        estado_r <= VARRENDO;
                        linhas_r <= linha_ativa(3'd0);
                    end else begin
                        estado_r <= PARADO;
                        linhas_r <= 7'h7F;
                    end
                end
                VARRENDO: begin
                    if (!bus.habilitar) begin
                        estado_r   <= PARADO;
                        presc_r    <= '0;
                        contador_r <= 3'd0;
                        linhas_r   <= 7'h7F;
                    end else if (presc_r == PRESC_FIM_LINHA) begin
                        presc_r    <= '0;
                        contador_r <= contador_prox_s;
`ifdef BRANCO_EN
                        estado_r   <= BRANCO;
                        linhas_r   <= 7'h7F;
`else
                        estado_r   <= VARRENDO;
                        linhas_r   <= linha_ativa(contador_prox_s);
`endif
                    end else begin
                        presc_r <= presc_r + PRESC_W'(1);
                    end
                end
`ifdef BRANCO_EN
                BRANCO: begin
                    if (!bus.habilitar) begin
                        estado_r   <= PARADO;
                        presc_r    <= '0;
                        contador_r <= 3'd0;
                        linhas_r   <= 7'h7F;
                    end else if (presc_r == PRESC_FIM_BRANCO) begin
                        estado_r <= VARRENDO;
                        presc_r  <= '0;
                        linhas_r <= linha_ativa(contador_r);
                    end else begin
                        presc_r <= presc_r + PRESC_W'(1);
                    end
                end
`endif
                default: begin
                    estado_r   <= PARADO;
                    presc_r    <= '0;
                    contador_r <= 3'd0;
                    linhas_r   <= 7'h7F;
                end
            endcase
        end
    end

endmodule
